// File: rtl/host_byte_bridge.sv
// host_byte_bridge: framed host byte stream <-> main cmd / 64-bit word handshakes.
// RX: a header byte selects either a command (H[7]=1) or a data frame (H=0x00)
// carrying a 16-bit big-endian word count. Each word is 8 bytes, MSB first.
// TX: each result word from main is shifted out as 8 bytes, MSB first.
module host_byte_bridge #(
    parameter int CMD_SIZE = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          hin,
    input  logic                hin_isReady,
    output logic                hin_canReceive,
    output logic [7:0]          hout,
    output logic                hout_isReady,
    input  logic                hout_canReceive,
    output logic [CMD_SIZE-1:0] cmd,
    output logic                cmd_isReady,
    input  logic                cmd_canReceive,
    output logic [63:0]         in,
    output logic                in_isReady,
    input  logic                in_canReceive,
    input  logic [63:0]         out,
    input  logic                out_isReady,
    output logic                out_canReceive,
    output logic                err_badHeader
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WORD, S_CMD
    } rx_state_t;

    // ---------------- RX path ----------------
    rx_state_t           state_q, state_d;
    logic [7:0]          len_hi_q, len_hi_d;
    logic [15:0]         wcnt_q, wcnt_d;
    logic [2:0]          bidx_q, bidx_d;
    logic [55:0]         acc_q, acc_d;
    logic [63:0]         in_q, in_d;
    logic [CMD_SIZE-1:0] cmd_q, cmd_d;
    logic                err_q, err_d;
    logic                hin_fire;

    // Gated with rst_n so the port reads 0 while reset is held, yet is already
    // 1 in the first cycle after release (the state flop is IDLE at that point).
    assign hin_canReceive = rst_n & (state_q != S_WORD) & (state_q != S_CMD);
    assign hin_fire       = hin_isReady & hin_canReceive;
    assign cmd_isReady    = (state_q == S_CMD);
    assign in_isReady     = (state_q == S_WORD);
    assign cmd            = cmd_q;
    assign in             = in_q;
    assign err_badHeader  = err_q;

    // RX next-state: header decode, length capture, byte assembly, word handoff.
    always_comb begin
        state_d  = state_q;
        len_hi_d = len_hi_q;
        wcnt_d   = wcnt_q;
        bidx_d   = bidx_q;
        acc_d    = acc_q;
        in_d     = in_q;
        cmd_d    = cmd_q;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: if (hin_fire) begin
                if (hin[7]) begin
                    cmd_d   = hin[CMD_SIZE-1:0];
                    state_d = S_CMD;
                end else if (hin == 8'h00) begin
                    state_d = S_LEN_HI;
                end else begin
                    err_d = 1'b1;
                end
            end
            S_LEN_HI: if (hin_fire) begin
                len_hi_d = hin;
                state_d  = S_LEN_LO;
            end
            S_LEN_LO: if (hin_fire) begin
                wcnt_d  = {len_hi_q, hin};
                bidx_d  = 3'd0;
                state_d = ({len_hi_q, hin} == 16'd0) ? S_IDLE : S_DATA;
            end
            S_DATA: if (hin_fire) begin
                // bidx wraps 7 -> 0, so the next word starts clean.
                bidx_d = bidx_q + 3'd1;
                if (bidx_q == 3'd7) begin
                    in_d    = {acc_q, hin};
                    state_d = S_WORD;
                end else begin
                    acc_d = {acc_q[47:0], hin};
                end
            end
            S_WORD: if (in_canReceive) begin
                wcnt_d  = wcnt_q - 16'd1;
                state_d = (wcnt_q == 16'd1) ? S_IDLE : S_DATA;
            end
            S_CMD: if (cmd_canReceive) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // RX state registers; reset discards any partial word or pending length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            len_hi_q <= '0;
            wcnt_q   <= '0;
            bidx_q   <= '0;
            acc_q    <= '0;
            in_q     <= '0;
            cmd_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_hi_q <= len_hi_d;
            wcnt_q   <= wcnt_d;
            bidx_q   <= bidx_d;
            acc_q    <= acc_d;
            in_q     <= in_d;
            cmd_q    <= cmd_d;
            err_q    <= err_d;
        end
    end

    // ---------------- TX path ----------------
    logic [63:0] tx_sh_q, tx_sh_d;
    logic [3:0]  tx_cnt_q, tx_cnt_d;
    logic        out_fire, hout_fire;

    assign hout         = tx_sh_q[63:56];
    assign hout_isReady = (tx_cnt_q != 4'd0);
    assign hout_fire    = hout_isReady & hout_canReceive;
    // Accept a new word while the last byte is leaving, so words stream gap-free.
    assign out_canReceive = rst_n & ((tx_cnt_q == 4'd0) |
                                     ((tx_cnt_q == 4'd1) & hout_canReceive));
    assign out_fire = out_isReady & out_canReceive;

    // TX next-state: load on capture, otherwise shift one byte per hout transfer.
    always_comb begin
        tx_sh_d  = tx_sh_q;
        tx_cnt_d = tx_cnt_q;
        if (out_fire) begin
            tx_sh_d  = out;
            tx_cnt_d = 4'd8;
        end else if (hout_fire) begin
            tx_sh_d  = {tx_sh_q[55:0], 8'h00};
            tx_cnt_d = tx_cnt_q - 4'd1;
        end
    end

    // TX shift register and byte count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sh_q  <= '0;
            tx_cnt_q <= '0;
        end else begin
            tx_sh_q  <= tx_sh_d;
            tx_cnt_q <= tx_cnt_d;
        end
    end

endmodule

// File: tb/tb_host_byte_bridge.sv
// Scoreboard bench for host_byte_bridge: expected cmd/in/hout values are queued
// when stimulus is driven and compared as the DUT transfers them.
module tb_host_byte_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  hin;
    logic        hin_isReady, hin_canReceive;
    logic [7:0]  hout;
    logic        hout_isReady, hout_canReceive;
    logic [3:0]  cmd;
    logic        cmd_isReady, cmd_canReceive;
    logic [63:0] in;
    logic        in_isReady, in_canReceive;
    logic [63:0] out;
    logic        out_isReady, out_canReceive;
    logic        err_badHeader;

    host_byte_bridge #(.CMD_SIZE(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .hin(hin), .hin_isReady(hin_isReady), .hin_canReceive(hin_canReceive),
        .hout(hout), .hout_isReady(hout_isReady), .hout_canReceive(hout_canReceive),
        .cmd(cmd), .cmd_isReady(cmd_isReady), .cmd_canReceive(cmd_canReceive),
        .in(in), .in_isReady(in_isReady), .in_canReceive(in_canReceive),
        .out(out), .out_isReady(out_isReady), .out_canReceive(out_canReceive),
        .err_badHeader(err_badHeader)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    int cmd_cyc = 0, in_vld_cyc = 0, in_xfers = 0, err_cyc = 0;
    int hout_xfers = 0, h_mark = 0, h_first = 0, h_last = 0;
    logic        prev_hold = 1'b0;
    logic [63:0] prev_in = '0;
    logic        t3_done;

    logic [3:0]  exp_cmd[$];
    logic [63:0] exp_in[$];
    logic [7:0]  exp_hout[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: observe transfers at negedge (values that commit on the next rising edge).
    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_isReady) cmd_cyc++;
            if (err_badHeader) err_cyc++;
            if (cmd_isReady && cmd_canReceive) begin
                chk("cmd_expected", exp_cmd.size() != 0, 1);
                if (exp_cmd.size() != 0) chk("cmd_val", cmd, exp_cmd.pop_front());
            end
            if (in_isReady) begin
                in_vld_cyc++;
                chk("rx_locked", hin_canReceive, 0);
                if (prev_hold) chk("in_hold", in, prev_in);
            end
            prev_hold = in_isReady && !in_canReceive;
            prev_in   = in;
            if (in_isReady && in_canReceive) begin
                in_xfers++;
                chk("in_expected", exp_in.size() != 0, 1);
                if (exp_in.size() != 0) chk("in_val", in, exp_in.pop_front());
            end
            if (hout_isReady && hout_canReceive) begin
                if (hout_xfers == h_mark) h_first = cyc;
                h_last = cyc;
                hout_xfers++;
                chk("hout_expected", exp_hout.size() != 0, 1);
                if (exp_hout.size() != 0) chk("hout_val", hout, exp_hout.pop_front());
            end
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        hin = b;
        hin_isReady = 1'b1;
        @(negedge clk);
        while (!hin_canReceive && t < 300) begin t++; @(negedge clk); end
        if (!hin_canReceive) chk("hin_timeout", hin_canReceive, 1);
        @(posedge clk); #1;
        hin_isReady = 1'b0;
    endtask

    task automatic send_word_bytes(input logic [63:0] w);
        for (int k = 0; k < 8; k++) send_byte(w[63-8*k -: 8]);
    endtask

    task automatic push_out(input logic [63:0] w);
        int t = 0;
        out = w;
        out_isReady = 1'b1;
        @(negedge clk);
        while (!out_canReceive && t < 300) begin t++; @(negedge clk); end
        if (!out_canReceive) chk("out_timeout", out_canReceive, 1);
        @(posedge clk); #1;
        out_isReady = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_hin_cr"}, hin_canReceive, 0);
        chk({tag, "_out_cr"}, out_canReceive, 0);
        chk({tag, "_cmd_rdy"}, cmd_isReady, 0);
        chk({tag, "_in_rdy"}, in_isReady, 0);
        chk({tag, "_hout_rdy"}, hout_isReady, 0);
        chk({tag, "_cmd"}, cmd, 0);
        chk({tag, "_in"}, in, 0);
        chk({tag, "_hout"}, hout, 0);
        chk({tag, "_err"}, err_badHeader, 0);
    endtask

    initial begin
        int c0, i0, e0, t;
        rst_n = 1'b0;
        hin = '0; hin_isReady = 1'b0;
        out = '0; out_isReady = 1'b0;
        cmd_canReceive = 1'b1; in_canReceive = 1'b1; hout_canReceive = 1'b1;
        #2 check_reset_outputs("rst");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("post_rst_hin_cr", hin_canReceive, 1);
        chk("post_rst_out_cr", out_canReceive, 1);

        // 1: command header 0x83
        c0 = cmd_cyc; i0 = in_vld_cyc;
        exp_cmd.push_back(4'h3);
        send_byte(8'h83);
        repeat (4) @(posedge clk); #1;
        chk("t1_cmd_pulse", cmd_cyc - c0, 1);
        chk("t1_no_in", in_vld_cyc - i0, 0);

        // 2: single-word frame
        i0 = in_xfers;
        exp_in.push_back(64'h0102030405060708);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        send_word_bytes(64'h0102030405060708);
        repeat (3) @(posedge clk); #1;
        chk("t2_in_xfers", in_xfers - i0, 1);

        // 3: two-word frame with main stalled for 20 clk
        in_canReceive = 1'b0;
        i0 = in_xfers;
        t3_done = 1'b0;
        exp_in.push_back(64'h1011121314151617);
        exp_in.push_back(64'h18191A1B1C1D1E1F);
        fork
            begin
                send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
                send_word_bytes(64'h1011121314151617);
                send_word_bytes(64'h18191A1B1C1D1E1F);
                t3_done = 1'b1;
            end
        join_none
        repeat (20) @(posedge clk); #1;
        chk("t3_stalled_vld", in_isReady, 1);
        chk("t3_stalled_xfers", in_xfers - i0, 0);
        in_canReceive = 1'b1;
        t = 0;
        while (!t3_done && t < 500) begin t++; @(posedge clk); end
        #1;
        chk("t3_done", t3_done, 1);
        repeat (3) @(posedge clk); #1;
        chk("t3_in_xfers", in_xfers - i0, 2);

        // 4: zero-length frame, then command, then illegal header
        i0 = in_vld_cyc;
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        exp_cmd.push_back(4'h1);
        send_byte(8'h81);
        repeat (3) @(posedge clk); #1;
        chk("t4_no_in", in_vld_cyc - i0, 0);
        e0 = err_cyc;
        send_byte(8'h05);
        repeat (3) @(posedge clk); #1;
        chk("t4_err_pulse", err_cyc - e0, 1);
        chk("t4_idle", hin_canReceive, 1);
        exp_cmd.push_back(4'h2);
        send_byte(8'h82);
        repeat (3) @(posedge clk); #1;

        // 5: two result words serialised back to back
        h_mark = hout_xfers;
        for (int k = 0; k < 8; k++) exp_hout.push_back(8'(64'hA1B2C3D4E5F60718 >> (56 - 8*k)));
        for (int k = 0; k < 8; k++) exp_hout.push_back(8'(64'h1122334455667788 >> (56 - 8*k)));
        push_out(64'hA1B2C3D4E5F60718);
        push_out(64'h1122334455667788);
        t = 0;
        while (hout_xfers < h_mark + 16 && t < 100) begin t++; @(posedge clk); end
        #1;
        chk("t5_hout_count", hout_xfers - h_mark, 16);
        chk("t5_no_gap", h_last - h_first, 15);
        chk("t5_empty", hout_isReady, 0);

        // 6: reset mid-frame discards the partial word
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        rst_n = 1'b0;
        #1 check_reset_outputs("t6_rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        i0 = in_xfers;
        exp_in.push_back(64'hC0C1C2C3C4C5C6C7);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        send_word_bytes(64'hC0C1C2C3C4C5C6C7);
        repeat (3) @(posedge clk); #1;
        chk("t6_in_xfers", in_xfers - i0, 1);

        chk("sb_cmd_empty", exp_cmd.size(), 0);
        chk("sb_in_empty", exp_in.size(), 0);
        chk("sb_hout_empty", exp_hout.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
